// File: rtl/shift_pkg.sv
// shift_pkg: constants shared by the serial transmitter and its divider.
//   state_e : FSM state encoding (ST_IDLE, ST_SHIFT)
//   DIR_MSB : send MSB first (receiver shifts left, bit enters at D[0])
//   DIR_LSB : send LSB first (receiver shifts right, bit enters at D[N-1])
package shift_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam logic DIR_MSB = 1'b0;
    localparam logic DIR_LSB = 1'b1;

endpackage

// File: rtl/shift_tx_tick.sv
// shift_tx_tick: bit-period divider for the serial transmitter.
//   C    : clock
//   RN   : asynchronous active-low reset
//   EN   : high while a frame is being shifted; counter held at 0 otherwise
//   TICK : high in the last cycle of each bit period (DIV cycles long)
module shift_tx_tick #(
    parameter int DIV = 1
) (
    input  logic C,
    input  logic RN,
    input  logic EN,
    output logic TICK
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;

    generate
        if (DIV == 1) begin : g_nodiv
            // Every shifting cycle is the last cycle of its bit period.
            assign div_d = '0;
        end else begin : g_div
            always_comb begin
                div_d = div_q;
                if (!EN) begin
                    div_d = '0;
                end else if (div_q == DW'(DIV - 1)) begin
                    div_d = '0;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
        end
    endgenerate

    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign TICK = EN && (div_q == DW'(DIV - 1));

endmodule

// File: rtl/shift_tx.sv
// shift_tx: parallel-to-serial transmitter with receiver shift strobe.
//   C    : clock, all state changes on rising edge
//   RN   : asynchronous active-low reset
//   D    : parallel word, captured when a load is accepted
//   L    : load request, honoured only while RDY=1
//   DIR  : 0 = MSB first, 1 = LSB first; captured with D
//   RDY  : idle, a load will be accepted
//   SO   : serial data out
//   SE   : shift strobe, receiver samples SO on the edge where SE=1
//   DONE : pulse coincident with the final SE of a frame
// All outputs are decoded from registers; no input reaches an output
// without passing through a flop.
module shift_tx
    import shift_pkg::*;
#(
    parameter int N   = 4,
    parameter int DIV = 1
) (
    input  logic         C,
    input  logic         RN,
    input  logic [N-1:0] D,
    input  logic         L,
    input  logic         DIR,
    output logic         RDY,
    output logic         SO,
    output logic         SE,
    output logic         DONE
);

    localparam int CW = $clog2(N);

    state_e         state_q;
    state_e         state_d;
    logic [N-1:0]   sreg_q;
    logic [N-1:0]   sreg_d;
    logic           dir_q;
    logic           dir_d;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;
    logic           tick;
    logic           last_bit;

    shift_tx_tick #(
        .DIV (DIV)
    ) u_tick (
        .C    (C),
        .RN   (RN),
        .EN   (state_q == ST_SHIFT),
        .TICK (tick)
    );

    assign last_bit = tick && (cnt_q == CW'(N - 1));

    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            dir_q   <= DIR_MSB;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (L) begin
                    state_d = ST_SHIFT;
                    sreg_d  = D;
                    dir_d   = DIR;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    // The bit on SO has just been taken by the receiver.
                    if (dir_q == DIR_MSB) begin
                        sreg_d = {sreg_q[N-2:0], 1'b0};
                    end else begin
                        sreg_d = {1'b0, sreg_q[N-1:1]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (last_bit) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign RDY  = (state_q == ST_IDLE);
    assign SO   = (state_q == ST_SHIFT) &&
                  ((dir_q == DIR_MSB) ? sreg_q[N-1] : sreg_q[0]);
    assign SE   = tick;
    assign DONE = last_bit;

endmodule
